// File: rtl/multitau_pkg.sv
// Shared definitions for the multi-tau autocorrelator: default widths,
// per-stage FSM encoding, width derivations and read-address field helpers.
package multitau_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned AW_DEF = 32;

  // Per-stage state: waiting for a sample, or walking the lags.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MAC  = 1'b1
  } stage_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Stage-select field width of the read address.
  function automatic int unsigned sw_width(input int unsigned nstages);
    return clog2(nstages);
  endfunction

  // Lag-index width; the index field carries one extra bit for the count slot.
  function automatic int unsigned lw_width(input int unsigned lags);
    return clog2(lags);
  endfunction

  // Stage number from a zero-extended read address.
  function automatic int unsigned addr_stage(input logic [31:0] addr, input int unsigned lw);
    return addr >> (lw + 1);
  endfunction

  // Index field (LW+1 bits) from a zero-extended read address.
  function automatic int unsigned addr_index(input logic [31:0] addr, input int unsigned lw);
    return addr & ((32'd1 << (lw + 1)) - 32'd1);
  endfunction

endpackage

// File: rtl/multitau_stage.sv
// One tau stage: pair-wise binning to the next stage, delay line, sequential
// MAC over LAGS lags into saturating accumulators, sample counter, sticky
// drop/saturation flags and a combinational read mux.
module multitau_stage
  import multitau_pkg::*;
#(
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned LAGS = 16,
  localparam int unsigned LW  = lw_width(LAGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_vld_i,
  input  logic [LW:0]   rd_idx_i,
  output logic [AW-1:0] rd_val_o,
  output logic [DW-1:0] fwd_data_o,
  output logic          fwd_vld_o,
  output stage_state_e  state_o,
  output logic          ovf_o,
  output logic          sat_o
);

  localparam logic [LW-1:0] K_LAST  = LW'(LAGS - 1);
  localparam logic [LW:0]   IDX_CNT = (LW + 1)'(LAGS);

  stage_state_e  state_q, state_d;
  logic [LW-1:0] k_q;
  logic [DW-1:0] x_q;
  logic [DW-1:0] d_q   [LAGS];
  logic [AW-1:0] acc_q [LAGS];
  logic [AW-1:0] cnt_q;
  logic          phase_q;
  logic [DW-1:0] bin_q;
  logic [DW-1:0] fwd_data_q;
  logic          fwd_vld_q;
  logic          ovf_q;
  logic          sat_q;

  logic            accept;
  logic [2*DW-1:0] prod;
  logic [AW:0]     mac_sum;
  logic            mac_ovf;
  logic [DW:0]     pair_sum;

  // A strobe is only taken while idle; anything arriving mid-walk is dropped.
  assign accept   = in_vld_i && (state_q == ST_IDLE);
  assign prod     = x_q * d_q[k_q];
  assign mac_sum  = {1'b0, acc_q[k_q]} + {{(AW + 1 - 2 * DW){1'b0}}, prod};
  assign mac_ovf  = mac_sum[AW];
  assign pair_sum = {1'b0, bin_q} + {1'b0, in_data_i};

  // Next-state logic: IDLE -> MAC on a strobe, MAC -> IDLE after the last lag.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_vld_i) state_d = ST_MAC;
      ST_MAC:  if (k_q == K_LAST) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register plus latched sample and lag counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      x_q     <= '0;
    end else if (clr_i) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        x_q <= in_data_i;
        k_q <= '0;
      end else if (state_q == ST_MAC) begin
        k_q <= k_q + 1'b1;
      end
    end
  end

  // Delay line: d[0] is the newest accepted sample, older samples shift up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAGS; i++) d_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < LAGS; i++) d_q[i] <= '0;
    end else if (accept) begin
      d_q[0] <= in_data_i;
      for (int i = 1; i < LAGS; i++) d_q[i] <= d_q[i-1];
    end
  end

  // Saturating accumulators, one lag per MAC cycle; sticky sat flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAGS; i++) acc_q[i] <= '0;
      sat_q <= 1'b0;
    end else if (clr_i) begin
      for (int i = 0; i < LAGS; i++) acc_q[i] <= '0;
      sat_q <= 1'b0;
    end else if (state_q == ST_MAC) begin
      acc_q[k_q] <= mac_ovf ? '1 : mac_sum[AW-1:0];
      if (mac_ovf) sat_q <= 1'b1;
    end
  end

  // Saturating sample counter and sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (accept && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
      if (in_vld_i && (state_q == ST_MAC)) ovf_q <= 1'b1;
    end
  end

  // Pair-wise binning: every second accepted sample forwards the truncated mean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= 1'b0;
      bin_q      <= '0;
      fwd_data_q <= '0;
      fwd_vld_q  <= 1'b0;
    end else if (clr_i) begin
      phase_q    <= 1'b0;
      bin_q      <= '0;
      fwd_data_q <= '0;
      fwd_vld_q  <= 1'b0;
    end else begin
      fwd_vld_q <= accept && phase_q;
      if (accept) begin
        phase_q <= ~phase_q;
        if (!phase_q) bin_q <= in_data_i;
        else          fwd_data_q <= pair_sum[DW:1];
      end
    end
  end

  // Read mux: accumulators, then the sample count, zero beyond.
  always_comb begin
    rd_val_o = '0;
    if (rd_idx_i < IDX_CNT)       rd_val_o = acc_q[rd_idx_i[LW-1:0]];
    else if (rd_idx_i == IDX_CNT) rd_val_o = cnt_q;
  end

  assign fwd_data_o = fwd_data_q;
  assign fwd_vld_o  = fwd_vld_q;
  assign state_o    = state_q;
  assign ovf_o      = ovf_q;
  assign sat_o      = sat_q;

endmodule

// File: rtl/multitau_corr_core.sv
// Multi-tau autocorrelator core: NSTAGES chained stages, registered
// single-port readout, busy/ovf/sat status.
// Read handshake: rd_en in cycle t yields rd_data with a one-cycle rd_vld
// pulse in cycle t+1; reads never stall and may be issued every cycle.
module multitau_corr_core
  import multitau_pkg::*;
#(
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned NSTAGES = 5,
  parameter int unsigned LAGS    = 16,
  localparam int unsigned SW     = sw_width(NSTAGES),
  localparam int unsigned LW     = lw_width(LAGS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [DW-1:0]      din,
  input  logic               din_vld,
  input  logic               rd_en,
  input  logic [SW+LW:0]     rd_addr,
  output logic [AW-1:0]      rd_data,
  output logic               rd_vld,
  output logic               busy,
  output logic [NSTAGES-1:0] ovf,
  output logic [NSTAGES-1:0] sat
);

  // Strobe chain: entry 0 is the external input, entry s+1 is stage s output.
  logic [DW-1:0] chain_data [NSTAGES+1];
  logic          chain_vld  [NSTAGES+1];
  logic [AW-1:0] stage_rd   [NSTAGES];
  stage_state_e  stage_state[NSTAGES];
  logic [NSTAGES-1:0] busy_vec;

  logic [31:0]   rd_addr_ext;
  int unsigned   stage_sel;
  logic [LW:0]   rd_idx;
  logic [AW-1:0] rd_mux;
  logic [AW-1:0] rd_data_q, rd_data_d;
  logic          rd_vld_q;

  assign chain_data[0] = din;
  assign chain_vld[0]  = din_vld;

  assign rd_addr_ext = 32'(rd_addr);
  assign stage_sel   = addr_stage(rd_addr_ext, LW);
  assign rd_idx      = (LW + 1)'(addr_index(rd_addr_ext, LW));

  for (genvar s = 0; s < NSTAGES; s++) begin : g_stage
    multitau_stage #(
      .DW   (DW),
      .AW   (AW),
      .LAGS (LAGS)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (clr),
      .in_data_i  (chain_data[s]),
      .in_vld_i   (chain_vld[s]),
      .rd_idx_i   (rd_idx),
      .rd_val_o   (stage_rd[s]),
      .fwd_data_o (chain_data[s+1]),
      .fwd_vld_o  (chain_vld[s+1]),
      .state_o    (stage_state[s]),
      .ovf_o      (ovf[s]),
      .sat_o      (sat[s])
    );
    assign busy_vec[s] = (stage_state[s] == ST_MAC);
  end

  assign busy = |busy_vec;

  // Stage select; out-of-range stages read as zero.
  always_comb begin
    rd_mux = '0;
    for (int unsigned s = 0; s < NSTAGES; s++) begin
      if (stage_sel == s) rd_mux = stage_rd[s];
    end
  end

  // Next read data: load on a request, otherwise hold.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = rd_mux;
  end

  // Read output register; a read overlapping clr still completes but returns 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else if (clr) begin
      rd_data_q <= '0;
      rd_vld_q  <= rd_en;
    end else begin
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_en;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_vld  = rd_vld_q;

endmodule

// File: tb/tb_multitau_corr_core.sv
// Directed bench for multitau_corr_core: a default instance (AW=32) and an
// AW=16 instance share the same stimulus.
module tb_multitau_corr_core;

  localparam int unsigned DW = 8;
  localparam int unsigned NS = 5;
  localparam int unsigned LG = 16;
  localparam int unsigned LW = 4;
  localparam int unsigned AWD = 8;

  logic           clk;
  logic           rst_n;
  logic           clr;
  logic [DW-1:0]  din;
  logic           din_vld;
  logic           rd_en;
  logic [AWD-1:0] rd_addr;
  logic [31:0]    rd_data;
  logic           rd_vld;
  logic           busy;
  logic [NS-1:0]  ovf;
  logic [NS-1:0]  sat;
  logic [15:0]    rd_data16;
  logic           rd_vld16;
  logic           busy16;
  logic [NS-1:0]  ovf16;
  logic [NS-1:0]  sat16;

  int n_checks;
  int n_fail;

  multitau_corr_core #(.DW(DW), .AW(32), .NSTAGES(NS), .LAGS(LG)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .din(din), .din_vld(din_vld),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_vld(rd_vld),
    .busy(busy), .ovf(ovf), .sat(sat)
  );

  multitau_corr_core #(.DW(DW), .AW(16), .NSTAGES(NS), .LAGS(LG)) dut16 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .din(din), .din_vld(din_vld),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data16), .rd_vld(rd_vld16),
    .busy(busy16), .ovf(ovf16), .sat(sat16)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Checking task
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [DW-1:0] v);
    @(negedge clk);
    din = v;
    din_vld = 1'b1;
    @(negedge clk);
    din_vld = 1'b0;
  endtask

  // Strobe, then pad so the next strobe lands gap cycles later.
  task automatic send_gap(input logic [DW-1:0] v, input int gap);
    send(v);
    idle(gap - 2);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 2000) chk("busy_timeout", 64'(busy), 64'd0);
  endtask

  function automatic logic [AWD-1:0] mk_addr(input int unsigned st, input int unsigned idx);
    return AWD'((st << (LW + 1)) | idx);
  endfunction

  task automatic rd(input int unsigned st, input int unsigned idx,
                    output logic [31:0] d32, output logic [15:0] d16);
    @(negedge clk);
    rd_en = 1'b1;
    rd_addr = mk_addr(st, idx);
    @(negedge clk);
    rd_en = 1'b0;
    chk("rd_vld", 64'(rd_vld), 64'd1);
    d32 = rd_data;
    d16 = rd_data16;
  endtask

  task automatic chk_rd(input string tag, input int unsigned st, input int unsigned idx,
                        input logic [31:0] exp);
    logic [31:0] d32;
    logic [15:0] d16;
    rd(st, idx, d32, d16);
    chk(tag, 64'(d32), 64'(exp));
  endtask

  task automatic chk_rd16(input string tag, input int unsigned st, input int unsigned idx,
                          input logic [15:0] exp);
    logic [31:0] d32;
    logic [15:0] d16;
    rd(st, idx, d32, d16);
    chk(tag, 64'(d16), 64'(exp));
  endtask

  // Stimulus and scoreboard
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    clr      = 1'b0;
    din      = '0;
    din_vld  = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    #23;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    chk("rst_rd_vld", 64'(rd_vld), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_sat", 64'(sat), 64'd0);

    // 1: ten samples of 3, spacing 20
    for (int i = 0; i < 10; i++) send_gap(8'd3, 20);
    wait_idle();
    for (int k = 0; k < 16; k++)
      chk_rd($sformatf("t1_s0_acc%0d", k), 0, k, (k < 10) ? 32'(9 * (10 - k)) : 32'd0);
    chk_rd("t1_s0_cnt", 0, LG, 32'd10);
    for (int k = 0; k < 6; k++)
      chk_rd($sformatf("t1_s1_acc%0d", k), 1, k, (k < 5) ? 32'(9 * (5 - k)) : 32'd0);
    chk_rd("t1_s1_cnt", 1, LG, 32'd5);
    chk_rd("t1_s2_cnt", 2, LG, 32'd2);
    chk("t1_ovf", 64'(ovf), 64'd0);
    chk("t1_sat", 64'(sat), 64'd0);

    // 2: binning truncation, 5 then 6
    pulse_clr();
    send_gap(8'd5, 20);
    send(8'd6);
    wait_idle();
    chk_rd("t2_s0_acc0", 0, 0, 32'd61);
    chk_rd("t2_s0_acc1", 0, 1, 32'd30);
    chk_rd("t2_s1_acc0", 1, 0, 32'd25);
    chk_rd("t2_s1_cnt", 1, LG, 32'd1);

    // 3: overflow at spacing 5, none at 17, drop again at 16
    pulse_clr();
    send_gap(8'd2, 5);
    send(8'd2);
    wait_idle();
    chk("t3_ovf", 64'(ovf), 64'd1);
    chk_rd("t3_s0_cnt", 0, LG, 32'd1);
    chk_rd("t3_s0_acc0", 0, 0, 32'd4);
    chk_rd("t3_s1_cnt", 1, LG, 32'd0);
    pulse_clr();
    send_gap(8'd2, 17);
    send(8'd2);
    wait_idle();
    chk("t3_gap17_ovf", 64'(ovf), 64'd0);
    chk_rd("t3_gap17_cnt", 0, LG, 32'd2);
    chk_rd("t3_gap17_acc0", 0, 0, 32'd8);
    pulse_clr();
    send_gap(8'd2, 16);
    send(8'd2);
    wait_idle();
    chk("t3_gap16_ovf", 64'(ovf), 64'd1);
    chk_rd("t3_gap16_cnt", 0, LG, 32'd1);

    // 4: saturation on the AW=16 instance
    pulse_clr();
    send_gap(8'd255, 20);
    send(8'd255);
    wait_idle();
    chk_rd16("t4_s0_acc0", 0, 0, 16'd65535);
    chk("t4_sat16", 64'(sat16), 64'd1);
    chk_rd16("t4_s0_acc1", 0, 1, 16'd65025);
    chk_rd16("t4_s1_acc0", 1, 0, 16'd65025);
    chk_rd("t4_wide_acc0", 0, 0, 32'd130050);
    chk("t4_sat32", 64'(sat), 64'd0);

    // 5a: clr mid-MAC (sat16 still set from the previous test)
    send(8'd3);
    send(8'd3);
    chk("t5_busy_before", 64'(busy), 64'd1);
    chk("t5_ovf_before", 64'(ovf), 64'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t5_busy_after_clr", 64'(busy), 64'd0);
    chk("t5_ovf_after_clr", 64'(ovf), 64'd0);
    chk("t5_sat16_after_clr", 64'(sat16), 64'd0);
    idle(20);
    chk_rd("t5_acc0", 0, 0, 32'd0);
    chk_rd("t5_cnt", 0, LG, 32'd0);

    // 5b: async reset pulse between edges
    send(8'd3);
    send(8'd3);
    chk_rd("t5b_cnt_pre", 0, LG, 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5b_busy", 64'(busy), 64'd0);
    chk("t5b_ovf", 64'(ovf), 64'd0);
    chk("t5b_rd_data", 64'(rd_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_rd("t5b_cnt_post", 0, LG, 32'd0);

    // 6: coincident read returns the pre-update value
    send(8'd3);
    wait_idle();
    @(negedge clk);
    din = 8'd2;
    din_vld = 1'b1;
    @(negedge clk);
    din_vld = 1'b0;
    rd_en = 1'b1;
    rd_addr = mk_addr(0, 0);
    @(negedge clk);
    rd_en = 1'b0;
    chk("t6_coinc_vld", 64'(rd_vld), 64'd1);
    chk("t6_coinc_old", 64'(rd_data), 64'd9);
    wait_idle();

    // 6: back-to-back reads
    @(negedge clk);
    rd_en = 1'b1;
    rd_addr = mk_addr(0, 0);
    @(negedge clk);
    chk("t6_b2b_vld0", 64'(rd_vld), 64'd1);
    chk("t6_b2b_acc0", 64'(rd_data), 64'd13);
    rd_addr = mk_addr(0, LG);
    @(negedge clk);
    chk("t6_b2b_vld1", 64'(rd_vld), 64'd1);
    chk("t6_b2b_cnt", 64'(rd_data), 64'd2);
    rd_addr = mk_addr(0, LG + 1);
    @(negedge clk);
    chk("t6_b2b_vld2", 64'(rd_vld), 64'd1);
    chk("t6_b2b_idx17", 64'(rd_data), 64'd0);
    rd_addr = mk_addr(0, 1);
    @(negedge clk);
    chk("t6_b2b_acc1", 64'(rd_data), 64'd6);
    rd_addr = mk_addr(NS, 0);
    @(negedge clk);
    rd_en = 1'b0;
    chk("t6_b2b_vld4", 64'(rd_vld), 64'd1);
    chk("t6_b2b_stage5", 64'(rd_data), 64'd0);
    @(negedge clk);
    chk("t6_vld_pulse", 64'(rd_vld), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multitau_corr_core.md
Name: multitau_corr_core

Overview:
Parametrised multi-tau autocorrelator core. It replaces the fixed five-stage / fixed-size correlator with NSTAGES identical stages of LAGS lags each. Each stage bins its input pair-wise into the next stage, accumulates x(n)·x(n−k) sequentially into saturating accumulators, and counts its samples for normalisation. Readout is a registered single-port interface, with sticky overflow and saturation status. The core sits between the photon-count front end and the host register bus.

Parameters:
DW, 8, sample width (all stages; binning averages, so width does not grow)
AW, 32, accumulator and sample-counter width
NSTAGES, 5, number of tau stages (1..8)
LAGS, 16, lags per stage (power of 2, 4..256)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear of all state
din  in  DW  input sample
din_vld  in  1  one-cycle strobe qualifying din
rd_en  in  1  read request
rd_addr  in  SW+LW+1  {stage[SW-1:0], index[LW:0]}, where SW=clog2(NSTAGES) and LW=clog2(LAGS)
rd_data  out  AW  read result
rd_vld  out  1  rd_data valid
busy  out  1  any stage MAC active
ovf  out  NSTAGES  sticky per stage: sample dropped because the stage was busy
sat  out  NSTAGES  sticky per stage: an accumulator saturated

Behaviour:
- Reset (async) or clr (sync, highest priority) zeroes the following; a clr mid-MAC aborts the walk; a clr during a read still completes that read but returns 0.
  - all accumulators, sample counters and delay lines
  - bin phase and bin register
  - FSM state (returns to IDLE)
  - rd_data, rd_vld, busy, ovf, sat
- Stage s input: stage 0 takes din/din_vld. Stage s+1 takes the strobe from stage s on every second accepted stage-s sample.
  - Forwarded value = (a+b)>>1, truncated, where a and b are the two consecutive accepted samples.
  - The bin phase toggles only on accepted samples.
- Per-stage FSM has two states, IDLE and MAC.
  - IDLE, input strobe: shift the delay line so d[0] = new sample and d[k] = previous d[k−1]. Latch x = new sample, set lag counter k = 0, increment the sample counter (saturating), go to MAC.
  - MAC: acc[k] += x·d[k] (product 2·DW bits, zero-extended to AW). k increments each cycle. After k = LAGS−1, go to IDLE.
  - A strobe arriving in MAC is dropped: set ovf[s]; no counter, bin or delay update.
  - A strobe arriving in the same cycle the FSM returns to IDLE is accepted.
- Timing: a sample accepted at the edge of cycle t updates acc[k] at the edge of cycle t+1+k. The stage is ready again in cycle t+LAGS+1. The minimum din_vld spacing without loss is LAGS+1 cycles.
- Lag k uses x(n)·x(n−k). Unfilled delay taps hold 0 and therefore contribute 0.
- Saturation: if acc+product exceeds 2^AW−1, the accumulator holds 2^AW−1 and sat[s] is set. The sample counter also saturates, but does not set sat.
- busy = OR of all stages in MAC.
- Read (rd_en at cycle t): rd_data and rd_vld=1 are presented at t+1; rd_vld is a single-cycle pulse. Back-to-back reads are allowed.
  - index < LAGS returns acc[stage][index].
  - index == LAGS returns the stage sample count.
  - Any other index, or stage ≥ NSTAGES, returns 0.
  - A read of an address being written in the same cycle returns the pre-update value.
- The read port never stalls the MACs. The host freezes the input (stops din_vld and waits for busy=0) to get a consistent snapshot.

Decomposition:
- Package multitau_pkg holds:
  - the clog2 function
  - SW and LW derivations
  - the address field split helpers
  - the DW/AW default constants
- Sub-module multitau_stage (one per stage, generated NSTAGES times) contains:
  - the bin register and phase
  - the delay line
  - the FSM
  - the accumulators and sample counter
  - the ovf and sat bits
  - a combinational read mux
- The top level contains the generate loop, the stage-to-stage strobe chain, the registered read mux, and the busy/ovf/sat concatenation.

Test Plan:
1. Defaults (AW=32, LAGS=16). Send 10 samples of value 3, spaced 20 cycles, then wait for busy=0.
   - Stage 0: acc[k] = 9·(10−k) for k<10, 0 for k≥10; count = 10.
   - Stage 1: acc[k] = 9·(5−k) for k<5; count = 5.
   - Stage 2: count = 2.
   - ovf = 0, sat = 0.
2. Binning truncation: send 5 then 6 (spacing 20).
   - Stage 1 receives 5; stage 1 acc[0] = 25.
   - Stage 0: acc[0] = 61, acc[1] = 30.
3. Overflow: two din_vld strobes of value 2, 5 cycles apart.
   - ovf[0] = 1; stage 0 count = 1; acc[0] = 4.
   - Stage 1 count = 0.
   - Second strobe at spacing exactly 17 (LAGS+1) is accepted with no ovf.
4. Saturation: AW=16, two samples of 255 spaced 20.
   - Stage 0 acc[0] = 65535 and sat[0] = 1.
   - acc[1] = 65025; stage 1 acc[0] = 65025.
5. Clear and reset mid-MAC:
   - Assert clr at cycle t+3 after a sample: all reads return 0, busy drops the next cycle, ovf/sat are cleared.
   - Repeat with an async rst_n pulse between clock edges: outputs are 0 immediately.
6. Read port:
   - Back-to-back rd_en on index 0, LAGS, LAGS+1 and stage=NSTAGES return acc, count, 0, 0 with rd_vld on each following cycle.
   - A read of acc[0] coincident with its update returns the old value.
